// File: rtl/l2_cache_pkg.sv
// Shared types and geometry helpers for the block-granular L2 cache.
package l2_cache_pkg;

  typedef enum logic {IDLE, MISS_WAIT} state_t;

  function automatic int calc_num_sets(input int cache_size, input int block_size,
                                       input int num_ways);
    return cache_size / (block_size * num_ways);
  endfunction

  function automatic int calc_index_bits(input int num_sets);
    return (num_sets > 1) ? $clog2(num_sets) : 0;
  endfunction

  function automatic int calc_way_bits(input int num_ways);
    return $clog2(num_ways);
  endfunction

endpackage

// File: rtl/l2_victim_select.sv
// Picks the way to fill: lowest invalid way, else the set's round-robin pointer.
module l2_victim_select #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_BITS = 2
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_BITS-1:0] rr_ptr,
  output logic [WAY_BITS-1:0] victim,
  output logic                all_valid
);

  always_comb begin
    victim    = rr_ptr;
    all_valid = &valid;
    // Scan downward so the lowest-numbered invalid way is the last assignment.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/l2_cache.sv
// Set-associative write-through, write-allocate L2 cache; one address = one block.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 1024,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            l1_cache_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_cache_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out,
  output logic                             l1_block_valid,
  input  logic                             l1_cache_read,
  input  logic                             l1_cache_write,
  output logic                             l1_cache_ready,
  output logic                             l1_cache_hit,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
  input  logic                             mem_ready,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  output logic                             mem_read,
  output logic                             mem_write
);

  localparam int NUM_SETS   = calc_num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int INDEX_BITS = calc_index_bits(NUM_SETS);
  localparam int WAY_BITS   = calc_way_bits(NUM_WAYS);
  localparam int IDX_W      = (INDEX_BITS > 0) ? INDEX_BITS : 1;
  localparam int BLK_W      = BLOCK_SIZE * DATA_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [WAY_BITS-1:0]   rr_q    [NUM_SETS];
  logic [ADDR_WIDTH-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]      data_q  [NUM_SETS][NUM_WAYS];

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [IDX_W-1:0]      cur_idx;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way, victim, wr_way;
  logic                  all_valid, data_we;
  logic [BLK_W-1:0]      wr_block;

  // While a fill is outstanding the set is addressed by the latched miss address.
  assign cur_addr = (state == IDLE) ? l1_cache_addr : miss_addr;
  assign cur_idx  = IDX_W'(32'(cur_addr) % NUM_SETS);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_addr) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  l2_victim_select #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_victim (
    .valid     (valid_q[cur_idx]),
    .rr_ptr    (rr_q[cur_idx]),
    .victim    (victim),
    .all_valid (all_valid)
  );

  assign data_we  = !rst_n && (((state == IDLE) && l1_cache_write) ||
                               ((state == MISS_WAIT) && mem_ready));
  assign wr_way   = ((state == IDLE) && hit) ? hit_way : victim;
  assign wr_block = (state == IDLE) ? l1_cache_data_in : mem_data_block;

  always_ff @(posedge clk) begin
    if (data_we) data_q[cur_idx][wr_way] <= wr_block;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state             <= IDLE;
      miss_addr         <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      l1_block_valid    <= 1'b0;
      l1_cache_ready    <= 1'b0;
      l1_cache_hit      <= 1'b0;
      mem_addr          <= '0;
      mem_data_out      <= '0;
      l1_block_data_out <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      l1_block_valid <= 1'b0;
      l1_cache_ready <= 1'b0;
      mem_write      <= 1'b0;
      case (state)
        IDLE: begin
          if (l1_cache_write) begin
            mem_write      <= 1'b1;
            mem_addr       <= l1_cache_addr;
            mem_data_out   <= l1_cache_data_in;
            l1_cache_ready <= 1'b1;
            l1_cache_hit   <= hit;
            if (!hit) begin
              valid_q[cur_idx][victim] <= 1'b1;
              tag_q[cur_idx][victim]   <= l1_cache_addr;
              if (all_valid) rr_q[cur_idx] <= rr_q[cur_idx] + WAY_BITS'(1);
            end
          end else if (l1_cache_read) begin
            if (hit) begin
              l1_block_data_out <= data_q[cur_idx][hit_way];
              l1_block_valid    <= 1'b1;
              l1_cache_ready    <= 1'b1;
              l1_cache_hit      <= 1'b1;
            end else begin
              mem_read  <= 1'b1;
              mem_addr  <= l1_cache_addr;
              miss_addr <= l1_cache_addr;
              state     <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT: begin
          if (mem_ready) begin
            valid_q[cur_idx][victim] <= 1'b1;
            tag_q[cur_idx][victim]   <= miss_addr;
            if (all_valid) rr_q[cur_idx] <= rr_q[cur_idx] + WAY_BITS'(1);
            l1_block_data_out <= mem_data_block;
            l1_block_valid    <= 1'b1;
            l1_cache_ready    <= 1'b1;
            l1_cache_hit      <= 1'b0;
            mem_read          <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache in a single-set (CACHE_SIZE=128) configuration.
module tb_l2_cache;

  localparam int DW  = 32;
  localparam int AW  = 11;
  localparam int BS  = 32;
  localparam int BLK = BS * DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AW-1:0]  l1_cache_addr;
  logic [BLK-1:0] l1_cache_data_in;
  logic [BLK-1:0] l1_block_data_out;
  logic           l1_block_valid;
  logic           l1_cache_read;
  logic           l1_cache_write;
  logic           l1_cache_ready;
  logic           l1_cache_hit;
  logic [BLK-1:0] mem_data_block;
  logic           mem_ready;
  logic [AW-1:0]  mem_addr;
  logic [BLK-1:0] mem_data_out;
  logic           mem_read;
  logic           mem_write;

  int vectors = 0;
  int errors  = 0;

  l2_cache #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(128), .BLOCK_SIZE(BS), .NUM_WAYS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .l1_cache_addr(l1_cache_addr), .l1_cache_data_in(l1_cache_data_in),
    .l1_block_data_out(l1_block_data_out), .l1_block_valid(l1_block_valid),
    .l1_cache_read(l1_cache_read), .l1_cache_write(l1_cache_write),
    .l1_cache_ready(l1_cache_ready), .l1_cache_hit(l1_cache_hit),
    .mem_data_block(mem_data_block), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BLK-1:0] make_block(input logic [31:0] base);
    logic [BLK-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = base ^ 32'(i);
    return b;
  endfunction

  // Advance past one active edge; outputs are then sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    l1_cache_read  = 1'b0;
    l1_cache_write = 1'b0;
    mem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    l1_cache_addr = a;
    l1_cache_read = 1'b1;
    cyc();
    l1_cache_read = 1'b0;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [31:0] base);
    l1_cache_addr    = a;
    l1_cache_data_in = make_block(base);
    l1_cache_write   = 1'b1;
    cyc();
    l1_cache_write   = 1'b0;
  endtask

  task automatic give_fill(input logic [31:0] base);
    mem_data_block = make_block(base);
    mem_ready      = 1'b1;
    cyc();
    mem_ready      = 1'b0;
  endtask

  task automatic test_reset();
    l1_cache_addr    = '0;
    l1_cache_data_in = '0;
    mem_data_block   = '0;
    do_reset();
    vectors++;
    if ({mem_read, mem_write, l1_block_valid, l1_cache_ready, l1_cache_hit} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {mem_read, mem_write, l1_block_valid, l1_cache_ready, l1_cache_hit});
    end
    vectors++;
    if (mem_addr !== '0 || mem_data_out !== '0 || l1_block_data_out !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %h mdo0 %h bdo0 %h exp zero",
               mem_addr, mem_data_out[31:0], l1_block_data_out[31:0]);
    end
  endtask

  task automatic test_read_miss();
    issue_read(11'h00A);
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 11'h00A) begin
      errors++;
      $display("FAIL rmiss_req got mem_read %b addr %h exp 1 00a", mem_read, mem_addr);
    end
    vectors++;
    if (l1_cache_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmiss_noready got %b exp 0", l1_cache_ready);
    end
    give_fill(32'hDEADBEEF);
    vectors++;
    if ({l1_block_valid, l1_cache_ready, l1_cache_hit, mem_read} !== 4'b1100) begin
      errors++;
      $display("FAIL rmiss_done got v/r/h/mr %b exp 1100",
               {l1_block_valid, l1_cache_ready, l1_cache_hit, mem_read});
    end
    vectors++;
    if (l1_block_data_out[31*DW +: DW] !== 32'hDEADBEF0) begin
      errors++;
      $display("FAIL rmiss_word31 got %h exp deadbef0", l1_block_data_out[31*DW +: DW]);
    end
    cyc();
    vectors++;
    if (l1_block_valid !== 1'b0 || l1_cache_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmiss_pulse got v %b r %b exp 0 0", l1_block_valid, l1_cache_ready);
    end
  endtask

  task automatic test_read_hit();
    issue_read(11'h00A);
    vectors++;
    if ({l1_block_valid, l1_cache_ready, l1_cache_hit, mem_read} !== 4'b1110) begin
      errors++;
      $display("FAIL rhit_flags got v/r/h/mr %b exp 1110",
               {l1_block_valid, l1_cache_ready, l1_cache_hit, mem_read});
    end
    vectors++;
    if (l1_block_data_out[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rhit_data got %h exp deadbeef", l1_block_data_out[31:0]);
    end
  endtask

  task automatic test_write();
    issue_write(11'h014, 32'hA5A5A5A5);
    vectors++;
    if ({mem_write, l1_cache_ready, l1_cache_hit, l1_block_valid} !== 4'b1100 ||
        mem_addr !== 11'h014) begin
      errors++;
      $display("FAIL wmiss got mw/r/h/v %b addr %h exp 1100 014",
               {mem_write, l1_cache_ready, l1_cache_hit, l1_block_valid}, mem_addr);
    end
    vectors++;
    if (mem_data_out[31:0] !== 32'hA5A5A5A5 || mem_data_out[5*DW +: DW] !== 32'hA5A5A5A0) begin
      errors++;
      $display("FAIL wmiss_data got w0 %h w5 %h exp a5a5a5a5 a5a5a5a0",
               mem_data_out[31:0], mem_data_out[5*DW +: DW]);
    end
    issue_write(11'h014, 32'h5A5A5A5A);
    vectors++;
    if ({mem_write, l1_cache_ready, l1_cache_hit} !== 3'b111) begin
      errors++;
      $display("FAIL whit got mw/r/h %b exp 111", {mem_write, l1_cache_ready, l1_cache_hit});
    end
    cyc();
    vectors++;
    if (mem_write !== 1'b0) begin
      errors++;
      $display("FAIL whit_pulse got %b exp 0", mem_write);
    end
    issue_read(11'h014);
    vectors++;
    if (l1_cache_hit !== 1'b1 || l1_block_data_out[31:0] !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL whit_readback got hit %b data %h exp 1 5a5a5a5a",
               l1_cache_hit, l1_block_data_out[31:0]);
    end
  endtask

  task automatic test_eviction();
    do_reset();
    for (int a = 1; a <= 5; a++) begin
      issue_read(AW'(a));
      vectors++;
      if (mem_read !== 1'b1 || mem_addr !== AW'(a)) begin
        errors++;
        $display("FAIL evict_fill_req got mr %b addr %h exp 1 %h", mem_read, mem_addr, AW'(a));
      end
      give_fill(32'h1000_0000 + 32'(a));
    end
    issue_read(11'h002);
    vectors++;
    if (l1_cache_hit !== 1'b1 || mem_read !== 1'b0 ||
        l1_block_data_out[31:0] !== 32'h1000_0002) begin
      errors++;
      $display("FAIL evict_keep got hit %b mr %b data %h exp 1 0 10000002",
               l1_cache_hit, mem_read, l1_block_data_out[31:0]);
    end
    issue_read(11'h005);
    vectors++;
    if (l1_cache_hit !== 1'b1 || l1_block_data_out[31:0] !== 32'h1000_0005) begin
      errors++;
      $display("FAIL evict_new got hit %b data %h exp 1 10000005",
               l1_cache_hit, l1_block_data_out[31:0]);
    end
    issue_read(11'h001);
    vectors++;
    if (mem_read !== 1'b1 || l1_cache_ready !== 1'b0) begin
      errors++;
      $display("FAIL evict_gone got mr %b r %b exp 1 0", mem_read, l1_cache_ready);
    end
    give_fill(32'h1000_0001);
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    issue_read(11'h00A);
    give_fill(32'hDEADBEEF);
    issue_read(11'h030);
    cyc();
    vectors++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL miss_hold got %b exp 1", mem_read);
    end
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0;
    vectors++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got mem_read %b exp 0", mem_read);
    end
    issue_read(11'h00A);
    vectors++;
    if (mem_read !== 1'b1 || l1_cache_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_miss got mr %b r %b exp 1 0", mem_read, l1_cache_ready);
    end
    // Requests during MISS_WAIT must be ignored.
    issue_write(11'h040, 32'h1234_5678);
    vectors++;
    if (mem_write !== 1'b0 || l1_cache_ready !== 1'b0) begin
      errors++;
      $display("FAIL miss_ignore got mw %b r %b exp 0 0", mem_write, l1_cache_ready);
    end
    give_fill(32'hDEADBEEF);
  endtask

  task automatic test_read_write_together();
    l1_cache_addr    = 11'h040;
    l1_cache_data_in = make_block(32'hCAFE0000);
    l1_cache_read    = 1'b1;
    l1_cache_write   = 1'b1;
    cyc();
    idle_inputs();
    vectors++;
    if ({mem_write, mem_read, l1_block_valid, l1_cache_ready} !== 4'b1001 ||
        mem_addr !== 11'h040) begin
      errors++;
      $display("FAIL rw_both got mw/mr/v/r %b addr %h exp 1001 040",
               {mem_write, mem_read, l1_block_valid, l1_cache_ready}, mem_addr);
    end
    issue_read(11'h040);
    vectors++;
    if (l1_cache_hit !== 1'b1 || l1_block_data_out[31:0] !== 32'hCAFE0000) begin
      errors++;
      $display("FAIL rw_readback got hit %b data %h exp 1 cafe0000",
               l1_cache_hit, l1_block_data_out[31:0]);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write();
    test_eviction();
    test_reset_mid_miss();
    test_read_write_together();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/l2_cache.md
Name: l2_cache

Overview:
- Set-associative, block-granular L2 cache between an L1 cache and main memory.
- Every transfer is a whole block of BLOCK_SIZE words.
- Policy: write-through, write-allocate. Read misses fetch from memory; writes are forwarded to memory in the same cycle they complete.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 11, width of the block address (one address = one block).
- CACHE_SIZE, 1024, total capacity in words; NUM_SETS = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS), a power of two ≥1.
- BLOCK_SIZE, 32, words per block.
- NUM_WAYS, 4, associativity, a power of two ≥2.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset. One clock; reset is synchronous and active-high (the port keeps the codebase name rst_n; asserted = 1).
- l1_cache_addr, input, ADDR_WIDTH: block address of the request.
- l1_cache_data_in, input, BLOCK_SIZE×DATA_WIDTH: write block. Word i is at [i*DATA_WIDTH +: DATA_WIDTH].
- l1_block_data_out, output, BLOCK_SIZE×DATA_WIDTH: read block, same packing.
- l1_block_valid, output, 1: read data valid pulse.
- l1_cache_read, input, 1: read request.
- l1_cache_write, input, 1: write request.
- l1_cache_ready, output, 1: request-complete pulse.
- l1_cache_hit, output, 1: completed request hit.
- mem_data_block, input, BLOCK_SIZE×DATA_WIDTH: fill data from memory.
- mem_ready, input, 1: fill data valid.
- mem_addr, output, ADDR_WIDTH: memory block address.
- mem_data_out, output, BLOCK_SIZE×DATA_WIDTH: write-through data.
- mem_read, output, 1: fill request, held high until mem_ready.
- mem_write, output, 1: one-cycle write-through pulse.

Behaviour:
- All outputs are registered.
- Reset, sampled at a posedge:
  - All valid bits and round-robin pointers cleared; state = IDLE.
  - mem_read, mem_write, l1_block_valid, l1_cache_ready and l1_cache_hit cleared to 0.
  - mem_addr, mem_data_out and l1_block_data_out cleared to 0.
  - A reset during MISS_WAIT aborts the fill and drops mem_read at that edge.
- Address split:
  - index = l1_cache_addr[log2(NUM_SETS)-1:0]; index = 0 when NUM_SETS = 1.
  - Stored tag = the full ADDR_WIDTH address.
  - Per way: valid bit, tag, data block.
- Hit = some way in the indexed set is valid with a matching tag.
- Pulse outputs (l1_block_valid, l1_cache_ready, mem_write) default to 0 every cycle.
- l1_cache_hit and l1_block_data_out hold their last value.
- FSM states: IDLE, MISS_WAIT. Requests are sampled only in IDLE and are ignored in MISS_WAIT. If both read and write are asserted, write wins.
- IDLE, read hit (1-cycle latency):
  - At the sampling edge: l1_block_data_out = stored block, l1_block_valid = 1, l1_cache_ready = 1, l1_cache_hit = 1.
  - The cycle after the request shows the response.
- IDLE, read miss:
  - At the sampling edge: mem_read = 1, mem_addr = request address; address latched; go to MISS_WAIT.
- MISS_WAIT:
  - mem_read stays 1 until mem_ready is sampled high.
  - At that edge: write mem_data_block into the victim way and set its valid bit and tag.
  - l1_block_data_out = mem_data_block; l1_block_valid = 1; l1_cache_ready = 1; l1_cache_hit = 0; mem_read = 0; return to IDLE.
- IDLE, write (completes in 1 cycle; memory accepts writes without handshake):
  - At the sampling edge: mem_write = 1, mem_addr = address, mem_data_out = l1_cache_data_in, l1_cache_ready = 1.
  - Hit: overwrite the matching way; l1_cache_hit = 1.
  - Miss: allocate the victim way with l1_cache_data_in; l1_cache_hit = 0.
  - l1_block_valid stays 0.
- Victim selection:
  - Use the lowest-numbered invalid way in the set.
  - If all ways are valid, use the set's round-robin pointer, then increment it mod NUM_WAYS.
  - Write-through means there are no dirty lines and no write-back on eviction.

Decomposition:
- Shared package l2_cache_pkg:
  - state enum {IDLE, MISS_WAIT}.
  - localparam functions for NUM_SETS, INDEX_BITS, WAY_BITS.
- One sub-module, l2_victim_select: combinational; takes the valid bits and round-robin pointer, returns the victim way index.
- Tag/data arrays and the FSM live in l2_cache.

Test Plan (all scenarios use CACHE_SIZE=128, i.e. one set, with the other parameters at their defaults):
- Read miss: after reset, read addr 0x00A.
  - Next cycle: mem_read=1, mem_addr=0x00A.
  - Drive mem_data_block[i] = 0xDEADBEEF^i and mem_ready=1 for one cycle; the following cycle shows l1_block_valid=1, l1_cache_ready=1, l1_cache_hit=0.
- Read hit: read 0x00A again.
  - Next cycle: valid=1, ready=1, hit=1, l1_block_data_out[0]=0xDEADBEEF, mem_read=0.
- Write miss: write addr 0x014 with data[i] = 0xA5A5A5A5^i.
  - Next cycle: mem_write=1, mem_addr=0x014, mem_data_out[0]=0xA5A5A5A5, ready=1, hit=0.
- Write hit: write 0x014 with data[i] = 0x5A5A5A5A^i.
  - Next cycle: mem_write=1, ready=1, hit=1.
  - Then read 0x014: hit, data_out[0]=0x5A5A5A5A.
- Eviction:
  - Fill addresses 0x001–0x004 via read misses, then read-miss 0x005 (evicts way 0, i.e. 0x001).
  - Reading 0x002 hits; reading 0x001 misses with mem_read=1.
- Reset mid-miss and request filtering:
  - Read miss 0x030, assert reset during MISS_WAIT: mem_read=0 next cycle, and a read of 0x00A afterwards misses.
  - Read and write together in IDLE: the write is performed (mem_write=1).
